mem_request_scheduler: RTL
==========================

Name: mem_request_scheduler

Overview:
- Shares one single-outstanding memory port between NUM_REQ requesters, for example the fetch, load/store and debug masters.
- Sits between the requesters and one consumer port of the SDRAM memory interface.
- Arbitrates round-robin, issues exactly one request at a time and waits for completion.
- Routes the read data or write acknowledge back to the winning requester, with a timeout-based error path.

Parameters:
- DATA_WIDTH, 32, address and data width; matches the codebase global data width.
- NUM_REQ, 4, number of requesters; supported range 2..8.
- TIMEOUT_CYCLES, 16384, maximum WAIT cycles before a request is aborted with an error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid; held until the matching req_ready pulse
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_address  in  NUM_REQ*DATA_WIDTH  flattened; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_writeData  in  NUM_REQ*DATA_WIDTH  flattened, same packing as req_address
- req_ready  out  NUM_REQ  one-hot, one-cycle pulse: request accepted
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: request complete
- rsp_readData  out  DATA_WIDTH  shared read data bus, qualified by rsp_valid
- rsp_error  out  1  qualified by rsp_valid: request timed out
- busy  out  1  high in every state except IDLE
- mem_address  out  DATA_WIDTH  to memory port
- mem_writeData  out  DATA_WIDTH  to memory port
- mem_writeEnable  out  1  one-cycle issue pulse
- mem_readEnable  out  1  one-cycle issue pulse
- mem_readData  in  DATA_WIDTH  read data from memory port
- mem_readDataValid  in  1  read complete
- mem_writeAck  in  1  write complete

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - State = IDLE, round-robin pointer = 0, timer = 0.
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any req_valid is set, select a winner by searching from the pointer upward with wrap-around.
  - Register winner index, address, write data and type; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - req_ready[winner] = 1.
  - mem_readEnable = ~type or mem_writeEnable = type, never both.
  - mem_address and mem_writeData are driven from the latched request and held stable until RESPOND exits.
  - Clear the timer; go to WAIT.
- WAIT:
  - Timer increments every cycle.
  - A read completes on mem_readDataValid: capture mem_readData, go to RESPOND with error = 0.
  - A write completes on mem_writeAck: go to RESPOND with error = 0.
  - The completion signal for the other type is ignored.
  - If the timer reaches TIMEOUT_CYCLES-1 with no completion, go to RESPOND with error = 1 and rsp_readData = 0.
  - Completion and timeout in the same cycle: completion wins.
- RESPOND (exactly 1 cycle):
  - rsp_valid[winner] = 1, rsp_error per above.
  - rsp_readData holds the captured data for reads and 0 for writes.
  - Pointer = (winner+1) mod NUM_REQ; go to IDLE.
- Latency:
  - req_valid seen in IDLE at cycle N: req_ready and the mem_*Enable pulse at N+1.
  - Completion seen at cycle M: rsp_valid at M+1.
  - Minimum spacing between back-to-back grants is 4 cycles.
- Stray completion signals in IDLE, ISSUE or RESPOND are ignored.
- A requester deasserting req_valid before req_ready is illegal and the scheduler does not check for it.
- A request already latched is still issued even if req_valid drops.
- Reset asserted mid-operation aborts the request:
  - No rsp_valid is generated.
  - The state returns to IDLE and all outputs are 0 on the next cycle.
- Timer width is clog2(TIMEOUT_CYCLES)+1 bits; the timer does not wrap within a request.

Optional Feature:
- Macro: MEM_SCHED_PRIO0_EN.
- Defined:
  - Requester 0 has fixed highest priority; if req_valid[0] is set in IDLE, requester 0 wins.
  - Requesters 1..NUM_REQ-1 arbitrate round-robin among themselves.
  - A requester-0 grant does not move the pointer.
- Undefined: pure round-robin over all requesters, as described above.

Test Plan:
- Single read: req_valid = 4'b0100, address 0x40; mem_readDataValid 10 cycles after issue with data 0xDEADBEEF.
  -> req_ready = 4'b0100 one cycle after request; mem_readEnable pulse with mem_address 0x40.
  -> rsp_valid = 4'b0100 one cycle after completion; rsp_readData 0xDEADBEEF; rsp_error 0.
- Fairness: all four req_valid held high, every request completed after 3 cycles.
  -> grant order is 0,1,2,3,0,1; no requester is granted twice before every other requester is granted once.
- Write: requester 1 writes 0x12345678 to 0x100; mem_writeAck after 70 cycles.
  -> mem_writeEnable pulse with mem_writeData 0x12345678.
  -> rsp_valid = 4'b0010 with rsp_readData 0; mem_readEnable never asserted.
- Timeout: TIMEOUT_CYCLES = 32, read with no completion.
  -> rsp_valid exactly 32 cycles after entering WAIT; rsp_error 1, rsp_readData 0.
  -> a late mem_readDataValid afterwards is ignored.
- Reset mid-WAIT: pulse reset for 1 cycle during WAIT.
  -> all outputs 0, no rsp_valid; the next request is granted to the lowest-index valid requester (pointer reset to 0).
- With MEM_SCHED_PRIO0_EN: requesters 0 and 2 continuously valid.
  -> requester 0 is granted every time and requester 2 is granted only when req_valid[0] is low in IDLE.
  -> without the macro, grants alternate 0,2,0,2.

Source files
------------

// File: rtl/mem_request_scheduler_if.sv
// Requester-side and memory-side buses of mem_request_scheduler.
// master is the scheduler's view; slave is the requesters' and memory's view.
interface mem_request_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_address;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_writeData;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_readData;
    logic                          rsp_error;
    logic                          busy;
    logic [DATA_WIDTH-1:0]         mem_address;
    logic [DATA_WIDTH-1:0]         mem_writeData;
    logic                          mem_writeEnable;
    logic                          mem_readEnable;
    logic [DATA_WIDTH-1:0]         mem_readData;
    logic                          mem_readDataValid;
    logic                          mem_writeAck;

    modport master (
        input  req_valid, req_write, req_address, req_writeData,
        input  mem_readData, mem_readDataValid, mem_writeAck,
        output req_ready, rsp_valid, rsp_readData, rsp_error, busy,
        output mem_address, mem_writeData, mem_writeEnable, mem_readEnable
    );

    modport slave (
        output req_valid, req_write, req_address, req_writeData,
        output mem_readData, mem_readDataValid, mem_writeAck,
        input  req_ready, rsp_valid, rsp_readData, rsp_error, busy,
        input  mem_address, mem_writeData, mem_writeEnable, mem_readEnable
    );
endinterface

// File: rtl/mem_request_scheduler.sv
// Round-robin scheduler sharing one single-outstanding memory port with a timeout error path.
// Optional MEM_SCHED_PRIO0_EN: requester 0 has fixed top priority and does not move the pointer.
module mem_request_scheduler #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_request_scheduler_if.master io_bus
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int IDX1_W = IDX_W + 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_win;
    logic [IDX_W-1:0]      w_pick;
    logic [IDX_W-1:0]      w_ptr_next;
    logic [IDX1_W-1:0]     w_idx;
    logic                  w_found;
    logic [TMR_W-1:0]      r_timer;
    logic                  r_write;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_done;
    logic                  w_timeout;

    // Search upward from the pointer with wrap-around; first valid requester wins.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + IDX1_W'(k);
            if (w_idx >= IDX1_W'(NUM_REQ)) begin
                w_idx = w_idx - IDX1_W'(NUM_REQ);
            end
            if (!w_found && io_bus.req_valid[w_idx[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[IDX_W-1:0];
            end
        end
`ifdef MEM_SCHED_PRIO0_EN
        if (io_bus.req_valid[0]) begin
            w_pick = '0;
        end
`endif
    end

    assign w_ptr_next = (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;

    always_comb begin
        w_next                 = r_state;
        w_done                 = 1'b0;
        w_timeout              = 1'b0;
        io_bus.req_ready       = '0;
        io_bus.rsp_valid       = '0;
        io_bus.rsp_readData    = '0;
        io_bus.rsp_error       = 1'b0;
        io_bus.busy            = (r_state != S_IDLE);
        io_bus.mem_address     = '0;
        io_bus.mem_writeData   = '0;
        io_bus.mem_writeEnable = 1'b0;
        io_bus.mem_readEnable  = 1'b0;
        if (r_state != S_IDLE) begin
            io_bus.mem_address   = r_addr;
            io_bus.mem_writeData = r_wdata;
        end
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                io_bus.req_ready       = ONE_HOT0 << r_win;
                io_bus.mem_writeEnable = r_write;
                io_bus.mem_readEnable  = ~r_write;
                w_next                 = S_WAIT;
            end
            S_WAIT: begin
                // Only the completion matching the issued type counts; completion beats timeout.
                w_done    = r_write ? io_bus.mem_writeAck : io_bus.mem_readDataValid;
                w_timeout = (r_timer == TMR_LAST);
                if (w_done || w_timeout) begin
                    w_next = S_RESPOND;
                end
            end
            S_RESPOND: begin
                io_bus.rsp_valid    = ONE_HOT0 << r_win;
                io_bus.rsp_readData = r_rdata;
                io_bus.rsp_error    = r_err;
                w_next              = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == S_RESPOND) begin
`ifdef MEM_SCHED_PRIO0_EN
                if (r_win != '0) begin
                    r_ptr <= w_ptr_next;
                end
`else
                r_ptr <= w_ptr_next;
`endif
            end
        end
    end

    // Request and response payload; only observable through state-gated outputs.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_found) begin
            r_win   <= w_pick;
            r_write <= io_bus.req_write[w_pick];
            r_addr  <= io_bus.req_address[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
            r_wdata <= io_bus.req_writeData[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
        end
        if (r_state == S_WAIT) begin
            r_err   <= ~w_done;
            r_rdata <= (w_done && !r_write) ? io_bus.mem_readData : '0;
        end
    end
endmodule
